// File: rtl/clip_mem_scheduler_pkg.sv
// Shared state encoding and default sizing for the clip memory scheduler.
package clip_mem_scheduler_pkg;

    localparam int DEF_ADDR_W = 17;
    localparam int DEF_DEPTH  = 100000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2,
        FINISH = 2'd3
    } sched_state_e;

endpackage

// File: rtl/clip_mem_scheduler_sample_addr_counter.sv
// Sample address counter: cleared at the start of an operation, stepped once per issued
// memory access, and compared against the current end-of-clip limit.
module clip_mem_scheduler_sample_addr_counter #(
    parameter int ADDR_W = 17
) (
    input  logic              clock_i,
    input  logic              Reset,
    input  logic              clear_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] limit_i,
    output logic [ADDR_W-1:0] count_o,
    output logic              at_limit_o
);

    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] count_d;

    // Clear has priority over increment so a fresh operation always starts at address 0.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o    = count_q;
    assign at_limit_o = (count_q == limit_i);

endmodule

// File: rtl/clip_mem_scheduler.sv
// Record/playback sequencer for the two clip BRAMs: arbitrates requests, issues one memory
// access per sample strobe and remembers each clip's recorded length to end playback.
module clip_mem_scheduler
    import clip_mem_scheduler_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clock_i,
    input  logic              Reset,
    input  logic              rec_req,
    input  logic              play_req,
    input  logic              stop_req,
    input  logic              rec_clip,
    input  logic              play_clip,
    input  logic              sample_stb,
    output logic [1:0]        mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic [1:0]        clip_valid
);

    sched_state_e      state_q, state_d;
    logic              clip_q, clip_d;
    logic [ADDR_W-1:0] len_q [2];
    logic [1:0]        mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              rd_valid_q;

    logic              cntClear;
    logic              access;
    logic              lenWrite;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] limit;
    logic              atLimit;

    // Recording runs to the full clip depth; playback runs to the stored length of its clip.
    assign limit = (state_q == RECORD) ? ADDR_W'(DEPTH) : len_q[clip_q];

    clip_mem_scheduler_sample_addr_counter #(
        .ADDR_W(ADDR_W)
    ) u_counter (
        .clock_i   (clock_i),
        .Reset     (Reset),
        .clear_i   (cntClear),
        .inc_i     (access),
        .limit_i   (limit),
        .count_o   (count),
        .at_limit_o(atLimit)
    );

    // The end check uses the counter value that already includes the access in flight, so the
    // last access completes before FINISH and an empty clip ends without touching memory.
    always_comb begin
        state_d  = state_q;
        clip_d   = clip_q;
        cntClear = 1'b0;
        access   = 1'b0;
        lenWrite = 1'b0;
        case (state_q)
            IDLE: begin
                if (rec_req) begin
                    state_d  = RECORD;
                    clip_d   = rec_clip;
                    cntClear = 1'b1;
                end else if (play_req) begin
                    state_d  = PLAY;
                    clip_d   = play_clip;
                    cntClear = 1'b1;
                end
            end
            RECORD, PLAY: begin
                if (stop_req || atLimit) begin
                    state_d  = FINISH;
                    lenWrite = (state_q == RECORD);
                end else if (sample_stb) begin
                    access = 1'b1;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (Reset) begin
            state_q    <= IDLE;
            clip_q     <= 1'b0;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            mem_en_q   <= 2'b00;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clip_q     <= clip_d;
            mem_en_q   <= access ? (clip_q ? 2'b10 : 2'b01) : 2'b00;
            mem_we_q   <= access && (state_q == RECORD);
            rd_valid_q <= (mem_en_q != 2'b00) && !mem_we_q;
            if (access) begin
                mem_addr_q <= count;
            end
            if (lenWrite) begin
                len_q[clip_q] <= count;
            end
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign rd_valid   = rd_valid_q;
    assign busy       = (state_q == RECORD) || (state_q == PLAY);
    assign done       = (state_q == FINISH);
    assign clip_valid = {len_q[1] != '0, len_q[0] != '0};

endmodule

// File: tb/tb_clip_mem_scheduler.sv
// Randomized bench for clip_mem_scheduler: each record/play operation is predicted at the
// transaction level from the stimulus and the clip lengths, then compared with a bus monitor.
module tb_clip_mem_scheduler;

    localparam int ADDR_W = 17;
    localparam int DEPTH  = 8;

    logic              clock_i = 1'b0;
    logic              Reset;
    logic              rec_req, play_req, stop_req, rec_clip, play_clip, sample_stb;
    logic [1:0]        mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              rd_valid, busy, done;
    logic [1:0]        clip_valid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lenModel [2];

    typedef struct {
        int         cyc;
        logic [1:0] en;
        logic       we;
        int         addr;
    } acc_t;

    acc_t accQ[$];
    int   rdQ[$];
    int   doneQ[$];

    clip_mem_scheduler #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clock_i   (clock_i),
        .Reset     (Reset),
        .rec_req   (rec_req),
        .play_req  (play_req),
        .stop_req  (stop_req),
        .rec_clip  (rec_clip),
        .play_clip (play_clip),
        .sample_stb(sample_stb),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .done      (done),
        .clip_valid(clip_valid)
    );

    always #5 clock_i = ~clock_i;

    always @(posedge clock_i) cyc <= cyc + 1;

    // Bus monitor: log every access, read-valid and done pulse with its cycle index.
    always @(negedge clock_i) begin
        if (!Reset) begin
            if (mem_en != 2'b00) accQ.push_back('{cyc, mem_en, mem_we, int'(mem_addr)});
            if (rd_valid) rdQ.push_back(cyc);
            if (done) doneQ.push_back(cyc);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // One record or play operation; stopAfter=0 means no stop request.
    task automatic applyStimulus(input bit isRec, input bit clip, input int nStbIn, input int stopAfter,
                                 input bit stopWithStb, input bit crossReq);
        int L, nAcc, nStb, reqCyc, stopCyc, expDone;
        bit stopEnds;
        int stbQ[$];
        accQ.delete();
        rdQ.delete();
        doneQ.delete();
        stopCyc  = 0;
        nStb     = nStbIn;
        L        = isRec ? DEPTH : lenModel[clip];
        stopEnds = (stopAfter > 0) && (stopAfter < L);
        nAcc     = stopEnds ? stopAfter : L;
        if (!stopEnds && nStb < L) nStb = L;
        if (stopAfter > 0 && nStb < stopAfter + 1) nStb = stopAfter + 1;

        if (isRec) begin
            rec_req  = 1'b1;
            rec_clip = clip;
            play_req = crossReq;
        end else begin
            play_req  = 1'b1;
            play_clip = clip;
        end
        reqCyc = cyc;
        tick();
        rec_req   = 1'b0;
        play_req  = 1'b0;
        rec_clip  = ~clip;
        play_clip = ~clip;

        for (int i = 0; i < nStb; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            if (stopAfter > 0 && i == stopAfter) begin
                stop_req = 1'b1;
                stopCyc  = cyc;
                if (!stopWithStb) begin
                    tick();
                    stop_req = 1'b0;
                end
            end
            sample_stb = 1'b1;
            stbQ.push_back(cyc);
            if (i == 0 && crossReq && nAcc > 0) begin
                if (isRec) play_req = 1'b1;
                else rec_req = 1'b1;
            end
            tick();
            sample_stb = 1'b0;
            stop_req   = 1'b0;
            play_req   = 1'b0;
            rec_req    = 1'b0;
        end

        for (int k = 0; k < 30 && doneQ.size() == 0; k++) tick();
        repeat (3) tick();

        if (stopEnds) expDone = stopCyc + 1;
        else if (nAcc == 0) expDone = reqCyc + 2;
        else expDone = stbQ[nAcc-1] + 2;

        checkOutput("done_count", doneQ.size(), 1);
        if (doneQ.size() > 0) checkOutput("done_cycle", doneQ[0], expDone);
        checkOutput("access_count", accQ.size(), nAcc);
        for (int j = 0; j < nAcc && j < accQ.size(); j++) begin
            checkOutput("access_addr", accQ[j].addr, j);
            checkOutput("access_en", accQ[j].en, clip ? 2 : 1);
            checkOutput("access_we", accQ[j].we, isRec);
            checkOutput("access_cycle", accQ[j].cyc, stbQ[j] + 1);
        end
        checkOutput("rd_valid_count", rdQ.size(), isRec ? 0 : nAcc);
        for (int j = 0; !isRec && j < nAcc && j < rdQ.size(); j++)
            checkOutput("rd_valid_cycle", rdQ[j], stbQ[j] + 2);

        if (isRec) lenModel[clip] = nAcc;
        checkOutput("clip_valid", clip_valid, {30'd0, lenModel[1] != 0, lenModel[0] != 0});
        checkOutput("busy_after", busy, 0);
        checkOutput("mem_en_idle", mem_en, 0);
    endtask

    initial begin
        bit rIsRec, rClip, rSws, rCross;
        int rStop, rNStb;

        Reset = 1'b1;
        rec_req = 1'b0; play_req = 1'b0; stop_req = 1'b0;
        rec_clip = 1'b0; play_clip = 1'b0; sample_stb = 1'b0;
        lenModel[0] = 0;
        lenModel[1] = 0;
        repeat (2) tick();
        checkOutput("reset_mem_en", mem_en, 0);
        checkOutput("reset_mem_we", mem_we, 0);
        checkOutput("reset_mem_addr", mem_addr, 0);
        checkOutput("reset_rd_valid", rd_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_clip_valid", clip_valid, 0);
        Reset = 1'b0;
        tick();

        // Directed sequences: full record, over-strobed playback, stopped record and its playback.
        applyStimulus(1'b1, 1'b0, 8, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 10, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 5, 3, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 6, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 6, 2, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 4, 0, 1'b0, 1'b1);

        for (int n = 0; n < 25; n++) begin
            rIsRec = 1'($urandom_range(0, 1));
            rClip  = 1'($urandom_range(0, 1));
            rSws   = 1'($urandom_range(0, 1));
            rCross = 1'($urandom_range(0, 1));
            rStop  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, DEPTH - 1)) : 0;
            rNStb  = int'($urandom_range(1, DEPTH + 2));
            applyStimulus(rIsRec, rClip, rNStb, rStop, rSws, rCross);
        end

        // Reset in the middle of playback, at the access for address 4.
        applyStimulus(1'b1, 1'b0, 8, 0, 1'b0, 1'b0);
        play_req  = 1'b1;
        play_clip = 1'b0;
        tick();
        play_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample_stb = 1'b1;
            tick();
            sample_stb = 1'b0;
        end
        checkOutput("midplay_addr", mem_addr, 4);
        checkOutput("midplay_en", mem_en, 1);
        checkOutput("midplay_busy", busy, 1);
        Reset = 1'b1;
        tick();
        checkOutput("midreset_mem_en", mem_en, 0);
        checkOutput("midreset_mem_we", mem_we, 0);
        checkOutput("midreset_mem_addr", mem_addr, 0);
        checkOutput("midreset_rd_valid", rd_valid, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_done", done, 0);
        checkOutput("midreset_clip_valid", clip_valid, 0);
        Reset = 1'b0;
        lenModel[0] = 0;
        lenModel[1] = 0;
        tick();

        // Both clips are now empty: playback must finish without any memory access.
        applyStimulus(1'b0, 1'b0, 2, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 3, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
